// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and the
// default qualification length (10 ms at a 50 MHz clock).
package button_debounce_pkg;

  typedef logic [1:0] dbState_t;

  localparam dbState_t STABLE_LOW  = 2'b00;
  localparam dbState_t WAIT_HIGH   = 2'b01;
  localparam dbState_t STABLE_HIGH = 2'b10;
  localparam dbState_t WAIT_LOW    = 2'b11;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_WIDTH       = 19;

endpackage

// File: rtl/button_debounce_if.sv
// Interface for the button debouncer.
// in   : raw, asynchronous and possibly bouncing button level
// out  : clean debounced level in the clock domain
// busy : a candidate level change is currently being qualified
interface button_debounce_if;

  logic in;
  logic out;
  logic busy;

  // The master side drives the raw button and observes the clean level.
  modport master (output in, input out, input busy);

  // The slave side is the debouncer itself.
  modport slave (input in, output out, output busy);

endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Single-bit two-flop synchronizer with a synchronous active-low reset.
// It can be reused for any asynchronous level input in the lab.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_sync1;
  logic r_sync2;

  // Pass the raw level through two flops so that metastability settles before use
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

  assign o_sync = r_sync2;

endmodule

// File: rtl/button_debounce.sv
// Button debouncer: synchronizes a raw button level, then accepts a level
// change only after the synchronized level has held for DEBOUNCE_CYCLES
// qualifying cycles. Its output feeds edge_detect, so one press gives one edge.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input logic             clock,
  input logic             reset,
  button_debounce_if.slave dbIf
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 w_syncLevel;
  dbState_t             r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_out;
  logic                 r_busy;

  sync_2ff uSync (
    .clock   (clock),
    .reset   (reset),
    .i_async (dbIf.in),
    .o_sync  (w_syncLevel)
  );

  // Filter FSM: a stable state moves to its wait state on a level change; a
  // wait state either gives up on any reversal or commits after the counter
  // reaches its last value. The counter is cleared on every transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        STABLE_LOW: begin
          if (w_syncLevel) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!w_syncLevel) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HIGH;
            r_cnt   <= '0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!w_syncLevel) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (w_syncLevel) begin
            r_state <= STABLE_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= STABLE_LOW;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbIf.out  = r_out;
  assign dbIf.busy = r_busy;

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions a raw, asynchronous, bouncing push-button/switch level into a clean single-clock-domain level.
- Sits directly upstream of edge_detect: its `out` drives edge_detect's `in`, so one physical press yields exactly one edge_out pulse.
- Two-flop synchronizer followed by a counter-qualified 4-state filter FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive synchronized-stable cycles required to accept a level change (10 ms at 50 MHz); legal range >= 1.
- CNT_WIDTH, 19, counter width; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset: reset==0 at a rising edge resets the block.
- in     input  1  raw asynchronous button level, may bounce.
- out    output 1  debounced level, registered; feeds edge_detect.in.
- busy   output 1  registered; 1 while a candidate level change is being qualified (WAIT_HIGH/WAIT_LOW).

Behaviour:
- Reset (reset==0 at a clock edge):
  - sync1=0, sync2=0, cnt=0, state=STABLE_LOW, out=0, busy=0.
  - Reset mid-qualification discards the pending change; reset has priority over all transitions.
- Synchronizer: sync1<=in, sync2<=sync1 every edge. Only sync2 is used by the FSM.
- FSM (registered state, out and busy updated on the same edge as the state transition):
  - STABLE_LOW:
    - sync2==1 -> WAIT_HIGH, cnt<=0, busy<=1.
    - Otherwise hold.
  - WAIT_HIGH:
    - sync2==0 -> STABLE_LOW, cnt<=0, busy<=0; bounce rejected, out stays 0.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, out<=1, busy<=0, cnt<=0.
    - Else cnt<=cnt+1.
  - STABLE_HIGH: symmetric to STABLE_LOW; sync2==0 -> WAIT_LOW, cnt<=0, busy<=1.
  - WAIT_LOW: symmetric to WAIT_HIGH.
    - sync2==1 -> STABLE_HIGH, out stays 1.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_LOW, out<=0.
    - Else cnt<=cnt+1.
- Latency:
  - `in` first sampled at edge E1 and held → out changes after edge E1+2+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=4: E1 sync1, E2 sync2, E3 enter WAIT, E7 out toggles.
- Rejection:
  - Any reversal of sync2 during WAIT_x returns to the prior stable state and restarts qualification from cnt=0 on the next change.
  - A pulse must persist DEBOUNCE_CYCLES+1 consecutive synchronized cycles (entry cycle plus DEBOUNCE_CYCLES qualifying cycles) to be accepted.
- Counter:
  - Unsigned, CNT_WIDTH bits; never wraps, since it is cleared at every state transition.
  - Reaching cnt==DEBOUNCE_CYCLES-1 is the only exit condition.
- out never changes outside a WAIT_x -> STABLE_x transition. out never glitches; at most one change per qualification window.
- Input held high through reset release: block starts in STABLE_LOW, qualifies, and raises out after the normal latency. This is intended: downstream sees one rising edge.
- Illegal/unused state encodings: next state STABLE_LOW, out<=0, busy<=0.

Decomposition:
- Shared package/include (debounce_defs):
  - State encodings STABLE_LOW=2'b00, WAIT_HIGH=2'b01, STABLE_HIGH=2'b10, WAIT_LOW=2'b11.
  - Default DEBOUNCE_CYCLES constant.
- One natural sub-module: sync_2ff (1-bit two-flop synchronizer with the same clock/reset), reusable for other asynchronous inputs in the lab.
- Counter and FSM stay in button_debounce.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3 override):
- Reset: hold reset=0 for 3 edges with in=1 -> out=0, busy=0. Release, keep in=1 -> busy=1 after 3rd edge, out=1 after 7th edge post-release, busy=0 same edge.
- Clean press: in 0->1 held 20 cycles -> out rises exactly 7 edges after first sampling edge. Chained to edge_detect -> exactly one edge_out pulse.
- Bounce rejection: in toggles 1,0,1,0 each lasting 2 cycles, then stays 0 -> out stays 0 throughout; busy pulses and returns to 0.
- Bounce then settle: in =1 for 2 cycles, 0 for 1 cycle, then 1 held -> out rises 7 edges after the final 0->1 sampling edge, not earlier.
- Release path: from out=1, in 1->0 held -> out falls 7 edges later. A 3-cycle low glitch from out=1 leaves out=1.
- Reset mid-qualification: in=1, assert reset=0 during WAIT_HIGH (busy=1) -> next edge out=0, busy=0, state STABLE_LOW. After release with in still 1, the full 7-edge qualification restarts from zero.
